// File: rtl/keypad_calc_if.sv
// Keypad-to-display bundle: key code/level in, BCD magnitude with flags out.
interface keypad_calc_if #(parameter int DIGITS = 4);
  logic [3:0]          key_value;
  logic                key_valid;
  logic [4*DIGITS-1:0] bcd_out;
  logic                neg;
  logic                err;
  logic                busy;

  modport master (output key_value, key_valid, input bcd_out, neg, err, busy);
  modport slave  (input key_value, key_valid, output bcd_out, neg, err, busy);
endinterface

// File: rtl/keypad_calc_engine.sv
// Decimal add/subtract calculator: BCD operand entry, signed accumulator,
// range check and a sequential double-dabble converter feeding the display.
module keypad_calc_engine #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 16
) (
  input  logic        clk,
  input  logic        reset_p,
  keypad_calc_if.slave kp
);
  localparam int DW   = 4*DIGITS;
  localparam int AW   = BIN_W + 1;           // signed accumulator
  localparam int XW   = BIN_W + 2;           // headroom for acc op operand
  localparam int CNTW = $clog2(DIGITS+1);
  localparam int CCW  = $clog2(BIN_W+1);
  localparam int unsigned MAXV = 10**DIGITS - 1;
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DIGITS);

  typedef enum logic [1:0] {ENTER_A, ENTER_B, RESULT, ERROR} state_t;

  // Weighted digit sum, Horner form.
  function automatic logic [BIN_W-1:0] bcd2bin(input logic [DW-1:0] b);
    logic [BIN_W-1:0] r;
    r = '0;
    for (int k = DIGITS-1; k >= 0; k--)
      r = r * BIN_W'(10) + BIN_W'(b[4*k +: 4]);
    return r;
  endfunction

  // One double-dabble iteration: correct nibbles >= 5, shift in next bit.
  function automatic logic [DW-1:0] dd_step(input logic [DW-1:0] b, input logic bit_in);
    logic [DW-1:0] t;
    t = b;
    for (int k = 0; k < DIGITS; k++)
      if (t[4*k +: 4] >= 4'd5) t[4*k +: 4] = t[4*k +: 4] + 4'd3;
    return {t[DW-2:0], bit_in};
  endfunction

  state_t                 state, state_n;
  logic                   kv_q;
  logic [DW-1:0]          entry, entry_n;
  logic [CNTW-1:0]        cnt, cnt_n;
  logic signed [AW-1:0]   acc, acc_n;
  logic                   op_sub, op_n;
  logic                   pend_vld, pend_vld_n;
  logic [3:0]             pend_key, pend_key_n;
  logic                   conv_busy, conv_neg;
  logic [CCW-1:0]         conv_cnt;
  logic [BIN_W-1:0]       conv_bin;
  logic [DW-1:0]          conv_bcd, dd_nxt;
  logic [DW-1:0]          acc_bcd;
  logic                   acc_neg;
  logic [DW-1:0]          bcd_q, bcd_n;
  logic                   neg_q, neg_n, err_q;

  logic                   evt, key_f, proc, acc_wr, ovf;
  logic                   conv_done, busy_n, direct_n;
  logic [3:0]             pkey;
  logic [BIN_W-1:0]       ebin_raw, acc_mag;
  logic signed [XW-1:0]   acc_x, ebin, calc;
  logic [XW-1:0]          calc_mag;

  // Key edge detect, pending buffer, FSM next state, display selection.
  always_comb begin
    evt      = kp.key_valid & ~kv_q;
    key_f    = evt && (kp.key_value == 4'hF);
    proc     = !conv_busy && (pend_vld || evt) && !key_f;
    pkey     = pend_vld ? pend_key : kp.key_value;
    ebin_raw = (cnt == '0) ? '0 : bcd2bin(entry);
    acc_x    = {acc[AW-1], acc};
    ebin     = {2'b00, ebin_raw};
    calc     = op_sub ? (acc_x - ebin) : (acc_x + ebin);
    calc_mag = calc[XW-1] ? -calc : calc;
    ovf      = calc_mag > XW'(MAXV);

    state_n = state;
    entry_n = entry;
    cnt_n   = cnt;
    acc_n   = acc;
    op_n    = op_sub;
    acc_wr  = 1'b0;

    if (proc) begin
      case (state)
        ENTER_A, ENTER_B: begin
          if (pkey <= 4'd9) begin
            if (cnt < CNT_MAX) begin
              entry_n = (entry << 4) | DW'(pkey);
              if (!(entry == '0 && pkey == 4'd0)) cnt_n = cnt + CNTW'(1);
            end
          end else if (pkey == 4'hC) begin
            entry_n = entry >> 4;
            if (cnt != '0) cnt_n = cnt - CNTW'(1);
          end else if (pkey == 4'hA || pkey == 4'hB) begin
            if (state == ENTER_A) begin
              acc_n   = {1'b0, ebin_raw};
              op_n    = (pkey == 4'hB);
              entry_n = '0;
              cnt_n   = '0;
              state_n = ENTER_B;
              acc_wr  = 1'b1;
            end else if (cnt == '0) begin
              op_n = (pkey == 4'hB);
            end else if (ovf) begin
              state_n = ERROR;
            end else begin
              acc_n   = calc[AW-1:0];
              op_n    = (pkey == 4'hB);
              entry_n = '0;
              cnt_n   = '0;
              acc_wr  = 1'b1;
            end
          end else if (pkey == 4'hE && state == ENTER_B) begin
            if (ovf) begin
              state_n = ERROR;
            end else begin
              acc_n   = calc[AW-1:0];
              entry_n = '0;
              cnt_n   = '0;
              state_n = RESULT;
              acc_wr  = 1'b1;
            end
          end
        end
        RESULT: begin
          if (pkey <= 4'd9) begin
            state_n = ENTER_A;
            entry_n = DW'(pkey);
            cnt_n   = (pkey != 4'd0) ? CNTW'(1) : '0;
          end else if (pkey == 4'hA || pkey == 4'hB) begin
            state_n = ENTER_B;
            op_n    = (pkey == 4'hB);
          end
        end
        default: ;
      endcase
    end

    // One-deep buffer: fill while busy, drain on the first idle edge.
    pend_vld_n = pend_vld;
    pend_key_n = pend_key;
    if (conv_busy) begin
      if (evt && !pend_vld) begin
        pend_vld_n = 1'b1;
        pend_key_n = kp.key_value;
      end
    end else if (pend_vld && evt) begin
      pend_key_n = kp.key_value;
    end else begin
      pend_vld_n = 1'b0;
    end

    acc_mag   = BIN_W'(acc_n[AW-1] ? -acc_n : acc_n);
    dd_nxt    = dd_step(conv_bcd, conv_bin[BIN_W-1]);
    conv_done = conv_busy && (conv_cnt == CCW'(1));
    busy_n    = acc_wr || (conv_busy && !conv_done);
    direct_n  = (state_n == ENTER_A) || (state_n == ENTER_B && cnt_n != '0);

    bcd_n = bcd_q;
    neg_n = neg_q;
    if (state_n == ERROR) begin
      bcd_n = '0;
      neg_n = 1'b0;
    end else if (direct_n) begin
      bcd_n = entry_n;
      neg_n = 1'b0;
    end else if (conv_done) begin
      bcd_n = dd_nxt;
      neg_n = conv_neg;
    end else if (!busy_n) begin
      bcd_n = acc_bcd;
      neg_n = acc_neg;
    end
  end

  // State, datapath and converter registers; F clears everything at once.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state <= ENTER_A; kv_q <= 1'b0; entry <= '0; cnt <= '0; acc <= '0;
      op_sub <= 1'b0; pend_vld <= 1'b0; pend_key <= '0;
      conv_busy <= 1'b0; conv_neg <= 1'b0; conv_cnt <= '0; conv_bin <= '0;
      conv_bcd <= '0; acc_bcd <= '0; acc_neg <= 1'b0;
      bcd_q <= '0; neg_q <= 1'b0; err_q <= 1'b0;
    end else begin
      kv_q <= kp.key_valid;
      if (key_f) begin
        state <= ENTER_A; entry <= '0; cnt <= '0; acc <= '0;
        op_sub <= 1'b0; pend_vld <= 1'b0; pend_key <= '0;
        conv_busy <= 1'b0; conv_neg <= 1'b0; conv_cnt <= '0; conv_bin <= '0;
        conv_bcd <= '0; acc_bcd <= '0; acc_neg <= 1'b0;
        bcd_q <= '0; neg_q <= 1'b0; err_q <= 1'b0;
      end else begin
        state    <= state_n;
        entry    <= entry_n;
        cnt      <= cnt_n;
        acc      <= acc_n;
        op_sub   <= op_n;
        pend_vld <= pend_vld_n;
        pend_key <= pend_key_n;
        if (acc_wr) begin
          conv_busy <= 1'b1;
          conv_cnt  <= CCW'(BIN_W);
          conv_bin  <= acc_mag;
          conv_bcd  <= '0;
          conv_neg  <= acc_n[AW-1];
        end else if (conv_busy) begin
          conv_bcd <= dd_nxt;
          conv_bin <= conv_bin << 1;
          conv_cnt <= conv_cnt - CCW'(1);
          if (conv_done) begin
            conv_busy <= 1'b0;
            acc_bcd   <= dd_nxt;
            acc_neg   <= conv_neg;
          end
        end
        bcd_q <= bcd_n;
        neg_q <= neg_n;
        err_q <= (state_n == ERROR);
      end
    end
  end

  assign kp.bcd_out = bcd_q;
  assign kp.neg     = neg_q;
  assign kp.err     = err_q;
  assign kp.busy    = conv_busy;
endmodule
